// File: rtl/fg_sram_arbiter.sv
// rtl/fg_sram_arbiter.sv - foreground SRAM arbiter: fixed-latency pixel reads, FIFO-buffered capture writes
module fg_sram_arbiter #(
    parameter int FB_WIDTH     = 640,
    parameter int ADDR_W       = 19,
    parameter int SRAM_LATENCY = 2,
    parameter int READ_LATENCY = 4,
    parameter int WFIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_active,
    input  logic [9:0]                    rd_x,
    input  logic [9:0]                    rd_y,
    output logic [15:0]                   fg_pixel_out,
    output logic                          fg_pixel_skip,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [9:0]                    wr_x,
    input  logic [9:0]                    wr_y,
    input  logic [15:0]                   wr_data,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [15:0]                   sram_wdata,
    output logic                          sram_data_oe,
    output logic                          sram_we_n,
    output logic                          sram_oe_n,
    input  logic [15:0]                   sram_rdata,
    output logic [$clog2(WFIFO_DEPTH):0]  wfifo_level,
    output logic                          wr_overflow
);
    localparam int PTR_W       = $clog2(WFIFO_DEPTH);
    localparam int LVL_W       = PTR_W + 1;
    localparam int DATA_STAGES = READ_LATENCY - SRAM_LATENCY - 1;

    typedef enum logic [1:0] {G_IDLE, G_READ, G_WRITE} grant_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(32'(y) * 32'(FB_WIDTH) + 32'(x));
    endfunction

    logic [ADDR_W+15:0]  fifo_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level_next;
    logic                push;
    logic                pop;
    grant_t              grant_d;
    grant_t              grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdata_q;
    logic [READ_LATENCY-1:0] act_sr;
    logic [15:0]         data_sr [DATA_STAGES];

    assign push = wr_valid & wr_ready;

    // A read always wins; a write needs a free slot that does not directly follow a read.
    always_comb begin
        grant_d = G_IDLE;
        if (rd_active) begin
            grant_d = G_READ;
        end else if (wfifo_level != '0 && grant_q != G_READ) begin
            grant_d = G_WRITE;
        end
    end

    assign pop        = (grant_d == G_WRITE);
    assign level_next = wfifo_level + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr(wr_x, wr_y), wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wfifo_level   <= '0;
            wr_ready      <= 1'b0;
            wr_overflow   <= 1'b0;
            grant_q       <= G_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_data_oe  <= 1'b0;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            act_sr        <= '0;
            fg_pixel_out  <= '0;
            fg_pixel_skip <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            wfifo_level <= level_next;
            wr_ready    <= (level_next < LVL_W'(WFIFO_DEPTH));
            if (wr_valid && !wr_ready) begin
                wr_overflow <= 1'b1;
            end

            // Grant stage: one cycle ahead of the pins.
            grant_q <= grant_d;
            if (grant_d == G_READ) begin
                addr_q <= pix_addr(rd_x, rd_y);
            end else if (grant_d == G_WRITE) begin
                {addr_q, wdata_q} <= fifo_mem[rd_ptr];
            end

            sram_oe_n    <= (grant_q != G_READ);
            sram_we_n    <= (grant_q != G_WRITE);
            sram_data_oe <= (grant_q == G_WRITE);
            if (grant_q != G_IDLE) begin
                sram_addr <= addr_q;
            end
            if (grant_q == G_WRITE) begin
                sram_wdata <= wdata_q;
            end

            // Return path is timed purely by the request shift register, never by write traffic.
            act_sr        <= {act_sr[READ_LATENCY-2:0], rd_active};
            fg_pixel_skip <= ~act_sr[READ_LATENCY-1];
            fg_pixel_out  <= act_sr[READ_LATENCY-1] ? data_sr[DATA_STAGES-1] : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        data_sr[0] <= sram_rdata;
        for (int i = 1; i < DATA_STAGES; i++) begin
            data_sr[i] <= data_sr[i-1];
        end
    end
endmodule

// File: tb/tb_fg_sram_arbiter.sv
// tb/tb_fg_sram_arbiter.sv - self-checking bench for fg_sram_arbiter
module tb_fg_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rd_active = 1'b0;
    logic [9:0]  rd_x = '0;
    logic [9:0]  rd_y = '0;
    logic [15:0] fg_pixel_out;
    logic        fg_pixel_skip;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [9:0]  wr_x = '0;
    logic [9:0]  wr_y = '0;
    logic [15:0] wr_data = '0;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_data_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [15:0] sram_rdata = '0;
    logic [4:0]  wfifo_level;
    logic        wr_overflow;

    always #5 clk = ~clk;

    fg_sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .rd_active(rd_active), .rd_x(rd_x), .rd_y(rd_y),
        .fg_pixel_out(fg_pixel_out), .fg_pixel_skip(fg_pixel_skip),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata),
        .wfifo_level(wfifo_level), .wr_overflow(wr_overflow)
    );

    int total = 0;
    int bad = 0;

    // SRAM model: unwritten locations hold a pattern derived from the address.
    logic [15:0] mem [int];

    function automatic logic [15:0] sram_val(input int a);
        logic [15:0] p;
        p = a[15:0] ^ 16'h5A5A;
        if (mem.exists(a)) p = mem[a];
        return p;
    endfunction

    always @(posedge clk) begin
        if (!sram_we_n) mem[int'(sram_addr)] = sram_wdata;
    end

    always @(posedge clk) begin
        sram_rdata <= sram_oe_n ? 16'h0000 : sram_val(int'(sram_addr));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] faddr(input int x, input int y);
        int t;
        t = (y * 640 + x) % 524288;
        return t[18:0];
    endfunction

    // Reference model: FIFO as a queue, expected pin/output events kept per future cycle.
    typedef struct { logic [18:0] a; logic [15:0] d; } went_t;
    went_t       m_q[$];
    int          m_prev;
    bit          m_ready;
    bit          m_ovf;
    int          m_k;
    int          p_kind [8];
    logic [18:0] p_addr [8];
    logic [15:0] p_data [8];
    bit          o_act  [8];
    logic [15:0] o_pix  [8];

    task automatic model_reset();
        m_q.delete();
        m_prev  = 0;
        m_ready = 0;
        m_ovf   = 0;
        m_k     = 0;
        for (int i = 0; i < 8; i++) begin
            p_kind[i] = 0;
            o_act[i]  = 0;
            o_pix[i]  = 16'h0000;
        end
    endtask

    task automatic tick(input bit rd, input int x, input int y,
                        input bit wv, input int wx, input int wy, input int wd);
        int    g;
        int    s;
        went_t e;
        rd_active = rd;
        rd_x      = 10'(x);
        rd_y      = 10'(y);
        wr_valid  = wv;
        wr_x      = 10'(wx);
        wr_y      = 10'(wy);
        wr_data   = 16'(wd);
        g = rd ? 1 : ((m_q.size() > 0 && m_prev != 1) ? 2 : 0);
        s = (m_k + 2) % 8;
        p_kind[s] = g;
        if (g == 1) p_addr[s] = faddr(x, y);
        if (g == 2) begin
            e = m_q.pop_front();
            p_addr[s] = e.a;
            p_data[s] = e.d;
        end
        s = (m_k + 5) % 8;
        o_act[s] = rd;
        o_pix[s] = rd ? sram_val(int'(faddr(x, y))) : 16'h0000;
        if (wv && !m_ready) m_ovf = 1;
        if (wv && m_ready) begin
            e.a = faddr(wx, wy);
            e.d = 16'(wd);
            m_q.push_back(e);
        end
        m_ready = (m_q.size() < 16);
        m_prev  = g;
        @(posedge clk);
        #1;
        m_k++;
        s = m_k % 8;
        chk("oe_n", sram_oe_n, p_kind[s] != 1);
        chk("we_n", sram_we_n, p_kind[s] != 2);
        chk("data_oe", sram_data_oe, p_kind[s] == 2);
        if (p_kind[s] != 0) chk("addr", sram_addr, p_addr[s]);
        if (p_kind[s] == 2) chk("wdata", sram_wdata, p_data[s]);
        chk("skip", fg_pixel_skip, !o_act[s]);
        chk("pixel", fg_pixel_out, o_pix[s]);
        chk("level", wfifo_level, m_q.size());
        chk("wr_ready", wr_ready, m_ready);
        chk("overflow", wr_overflow, m_ovf);
    endtask

    task automatic do_reset();
        rd_active = 0;
        wr_valid  = 0;
        rst_n     = 0;
        #2;
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_data_oe", sram_data_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_pixel", fg_pixel_out, 0);
        chk("rst_skip", fg_pixel_skip, 1);
        chk("rst_level", wfifo_level, 0);
        chk("rst_overflow", wr_overflow, 0);
        chk("rst_wr_ready", wr_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        bit          rd;
        int          x;
        int          y;
        bit          chk_a;
        bit          oe_n;
        int          addr;
        bit          skip;
        logic [15:0] pix;
    } vec_t;

    vec_t        tbl [11];
    int          nwe;
    bit          tr_oe [8];
    bit          tr_we [8];
    logic [18:0] tr_addr [8];
    logic [15:0] tr_data [8];
    bit          pat [8];

    initial begin
        tbl[0]  = '{1, 3,    2,    0, 1, 0,      1, 16'h0000};
        tbl[1]  = '{0, 0,    0,    1, 0, 1283,   1, 16'h0000};
        tbl[2]  = '{0, 0,    0,    0, 1, 0,      1, 16'h0000};
        tbl[3]  = '{0, 0,    0,    0, 1, 0,      1, 16'h0000};
        tbl[4]  = '{1, 1023, 1023, 0, 1, 0,      0, 16'hABCD};
        tbl[5]  = '{1, 639,  0,    1, 0, 131455, 1, 16'h0000};
        tbl[6]  = '{0, 0,    0,    1, 0, 639,    1, 16'h0000};
        tbl[7]  = '{0, 0,    0,    0, 1, 0,      1, 16'h0000};
        tbl[8]  = '{0, 0,    0,    0, 1, 0,      0, 16'h5B25};
        tbl[9]  = '{0, 0,    0,    0, 1, 0,      0, 16'h5825};
        tbl[10] = '{0, 0,    0,    0, 1, 0,      1, 16'h0000};
        mem[1283] = 16'hABCD;
        #1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].rd, tbl[i].x, tbl[i].y, 0, 0, 0, 0);
            chk("tbl_oe_n", sram_oe_n, tbl[i].oe_n);
            if (tbl[i].chk_a) chk("tbl_addr", sram_addr, tbl[i].addr);
            chk("tbl_skip", fg_pixel_skip, tbl[i].skip);
            chk("tbl_pixel", fg_pixel_out, tbl[i].pix);
        end

        // Sustained reads with the writer pushing: FIFO fills, no writes reach the pins.
        do_reset();
        nwe = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, i, 5, i > 0, 100 + i, 210, 16'h1000 + i);
            if (!sram_we_n) nwe++;
            if (i == 16) chk("ovf_before_17th", wr_overflow, 0);
            if (i == 17) chk("ovf_after_17th", wr_overflow, 1);
        end
        chk("fill_we_pulses", nwe, 0);
        chk("fill_level", wfifo_level, 16);
        chk("fill_wr_ready", wr_ready, 0);
        chk("fill_overflow", wr_overflow, 1);
        for (int i = 0; i < 22; i++) tick(0, 0, 0, 0, 0, 0, 0);
        chk("fill_drained", wfifo_level, 0);

        // Reads stop with three entries queued: one turnaround, then three writes.
        do_reset();
        tick(1, 7, 7, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 20 + i, 30, 1, 10 + i, 200, 16'h1111 * (i + 1));
        tick(1, 40, 30, 0, 0, 0, 0);
        for (int t = 0; t < 8; t++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            tr_oe[t]   = sram_oe_n;
            tr_we[t]   = sram_we_n;
            tr_addr[t] = sram_addr;
            tr_data[t] = sram_wdata;
        end
        chk("drain_last_read", tr_oe[0], 0);
        chk("drain_turn_we", tr_we[1], 1);
        chk("drain_turn_oe", tr_oe[1], 1);
        for (int j = 0; j < 3; j++) begin
            chk("drain_we", tr_we[2 + j], 0);
            chk("drain_addr", tr_addr[2 + j], 128010 + j);
            chk("drain_data", tr_data[2 + j], 16'h1111 * (j + 1));
        end
        chk("drain_done_we", tr_we[5], 1);
        chk("drain_level", wfifo_level, 0);
        chk("drain_wr_ready", wr_ready, 1);

        // Alternating reads and gaps: every gap is a turnaround, so no write.
        for (int i = 0; i < 3; i++) tick(1, i, 40, i < 2, 50 + i, 220, 16'h4000 + i);
        for (int i = 0; i < 8; i++) pat[i] = (i % 2 == 0) || (i == 7);
        nwe = 0;
        for (int i = 0; i < 8; i++) begin
            tick(pat[i], 30 + i, 41, 0, 0, 0, 0);
            if (!sram_we_n) nwe++;
        end
        chk("toggle_we_pulses", nwe, 0);
        chk("toggle_level", wfifo_level, 2);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0, 0, 0);

        // Push and pop together hold the level at five.
        for (int i = 0; i < 4; i++) tick(1, i, 50, 1, 60 + i, 230, 16'h5000 + i);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 1, 70 + i, 230, 16'h5100 + i);
            chk("level_hold5", wfifo_level, 5);
        end

        // Asynchronous reset in the middle of a write pulse.
        chk("we_low_before_rst", sram_we_n, 0);
        rst_n = 0;
        #1;
        chk("rst_async_we_n", sram_we_n, 1);
        chk("rst_async_data_oe", sram_data_oe, 0);
        rd_active = 0;
        wr_valid  = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_level", wfifo_level, 0);
        chk("post_rst_skip", fg_pixel_skip, 1);

        // Random traffic against the model; reads and writes use disjoint address ranges.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 99) < 60, $urandom_range(0, 639), $urandom_range(0, 99),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 639), $urandom_range(240, 299),
                 $urandom_range(0, 65535));
        end
        for (int i = 0; i < 40; i++) tick(0, 0, 0, 0, 0, 0, 0);
        chk("rand_drain_level", wfifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
